// File: rtl/fs_lut4.sv
// fs_lut4: a programmable 4-input, 1-output Boolean function cell.
// A 16-bit truth-table register is indexed by {a,b,c,d}, with a as the MSB.
// The table is reloaded through cfg_we_i/cfg_data_i and read back on tt_o.
// The result is either a flop or a purely combinational lookup, chosen by REGISTERED.
module fs_lut4 #(
    parameter logic [15:0] TT_DEFAULT = 16'h6996,
    parameter bit          REGISTERED = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        a_i,
    input  logic        b_i,
    input  logic        c_i,
    input  logic        d_i,
    input  logic        cfg_we_i,
    input  logic [15:0] cfg_data_i,
    output logic [15:0] tt_o,
    output logic        y_o
);

    logic [15:0] tt_q;
    logic [15:0] tt_d;
    logic [3:0]  idx;
    logic        lookup;

    assign idx    = {a_i, b_i, c_i, d_i};
    assign lookup = tt_q[idx];
    assign tt_o   = tt_q;

    // Next table value: take the new table on a write, otherwise hold.
    always_comb begin
        tt_d = tt_q;
        if (cfg_we_i) begin
            tt_d = cfg_data_i;
        end
    end

    // Table register. Reset wins over a write issued on the same edge.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            tt_q <= TT_DEFAULT;
        end else begin
            tt_q <= tt_d;
        end
    end

    generate
        if (REGISTERED) begin : g_reg
            logic y_q;

            // Registered lookup from the pre-edge table, so a write shows up one cycle later.
            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    y_q <= 1'b0;
                end else begin
                    y_q <= lookup;
                end
            end

            assign y_o = y_q;
        end else begin : g_comb
            assign y_o = rst_n_i ? lookup : 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_fs_lut4.sv
// Directed testbench for fs_lut4.
// It drives a registered and a combinational instance from the same stimulus.
module tb_fs_lut4;

   logic        clk = 1'b0;
   logic        rstN;
   logic        a, b, c, d;
   logic        cfgWe;
   logic [15:0] cfgData;
   logic [15:0] ttR, ttC;
   logic        yR, yC;

   int testsRun    = 0;
   int testsFailed = 0;

   logic [15:0] parity = 16'h6996;
   logic [15:0] modelTt;
   logic        expY;
   logic        expYC;

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   fs_lut4 #(.TT_DEFAULT(16'h6996), .REGISTERED(1'b1)) dutReg (
      .clk_i(clk), .rst_n_i(rstN),
      .a_i(a), .b_i(b), .c_i(c), .d_i(d),
      .cfg_we_i(cfgWe), .cfg_data_i(cfgData),
      .tt_o(ttR), .y_o(yR)
   );

   fs_lut4 #(.TT_DEFAULT(16'h6996), .REGISTERED(1'b0)) dutComb (
      .clk_i(clk), .rst_n_i(rstN),
      .a_i(a), .b_i(b), .c_i(c), .d_i(d),
      .cfg_we_i(cfgWe), .cfg_data_i(cfgData),
      .tt_o(ttC), .y_o(yC)
   );

   // Compare one observed value against its expected value and count the outcome.
   task checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drive one input vector, then step to 1 time unit after the next rising edge.
   task applyStimulus(input logic [3:0] idx, input logic we, input logic [15:0] data, input logic rn);
      {a, b, c, d} = idx;
      cfgWe   = we;
      cfgData = data;
      rstN    = rn;
      @(posedge clk);
      #1;
   endtask

   // Directed steps, followed by a randomized pass against a reference model.
   initial begin
      {a, b, c, d} = 4'd0;
      cfgWe   = 1'b0;
      cfgData = 16'h0000;
      rstN    = 1'b0;

      // Reset state.
      applyStimulus(4'd0, 1'b0, 16'h0000, 1'b0);
      applyStimulus(4'd0, 1'b0, 16'h0000, 1'b0);
      checkOutput("reset_y_reg", {15'd0, yR}, 16'h0000);
      checkOutput("reset_tt_reg", ttR, 16'h6996);
      checkOutput("reset_y_comb", {15'd0, yC}, 16'h0000);
      checkOutput("reset_tt_comb", ttC, 16'h6996);

      // Parity sweep with the default table.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(i[3:0], 1'b0, 16'h0000, 1'b1);
         checkOutput("parity_y_reg", {15'd0, yR}, {15'd0, parity[i]});
         checkOutput("parity_y_comb", {15'd0, yC}, {15'd0, parity[i]});
      end
      checkOutput("parity_tt", ttR, 16'h6996);

      // Load AND4 and sweep.
      applyStimulus(4'd0, 1'b1, 16'h8000, 1'b1);
      checkOutput("and4_load_tt", ttR, 16'h8000);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(i[3:0], 1'b0, 16'h0000, 1'b1);
         checkOutput("and4_y_reg", {15'd0, yR}, (i == 15) ? 16'h0001 : 16'h0000);
      end
      checkOutput("and4_tt", ttR, 16'h8000);

      // A write and a lookup on the same edge: the lookup sees the old table.
      applyStimulus(4'd0, 1'b1, 16'h6996, 1'b1);
      applyStimulus(4'd3, 1'b1, 16'h0000, 1'b1);
      checkOutput("same_edge_idx3_y", {15'd0, yR}, 16'h0000);
      checkOutput("same_edge_tt", ttR, 16'h0000);
      applyStimulus(4'd0, 1'b1, 16'h6996, 1'b1);
      applyStimulus(4'd1, 1'b1, 16'h0000, 1'b1);
      checkOutput("same_edge_idx1_old", {15'd0, yR}, 16'h0001);
      applyStimulus(4'd1, 1'b0, 16'h0000, 1'b1);
      checkOutput("next_cycle_idx1_new", {15'd0, yR}, 16'h0000);

      // A reset pulse discards a loaded table and drops a concurrent write.
      applyStimulus(4'd0, 1'b1, 16'hFFFE, 1'b1);
      checkOutput("load_fffe_tt", ttR, 16'hFFFE);
      applyStimulus(4'd5, 1'b1, 16'h0001, 1'b0);
      checkOutput("reset_drop_tt", ttR, 16'h6996);
      checkOutput("reset_drop_y", {15'd0, yR}, 16'h0000);
      checkOutput("reset_drop_y_comb", {15'd0, yC}, 16'h0000);
      applyStimulus(4'd1, 1'b0, 16'h0000, 1'b1);
      checkOutput("after_reset_idx1_y", {15'd0, yR}, 16'h0001);

      // Combinational instance follows the inputs between clock edges.
      rstN  = 1'b1;
      cfgWe = 1'b0;
      for (int i = 0; i < 16; i++) begin
         {a, b, c, d} = i[3:0];
         #5;
         checkOutput("comb_follow_y", {15'd0, yC}, {15'd0, parity[i]});
      end
      {a, b, c, d} = 4'd7;
      rstN = 1'b0;
      #1;
      checkOutput("comb_reset_y", {15'd0, yC}, 16'h0000);
      rstN = 1'b1;
      #1;
      checkOutput("comb_release_y", {15'd0, yC}, 16'h0001);

      // Randomized mix of writes, resets and inputs against a reference model.
      applyStimulus(4'd0, 1'b0, 16'h0000, 1'b0);
      modelTt = 16'h6996;
      for (int n = 0; n < 200; n++) begin
         logic [3:0]  rIdx;
         logic        rWe;
         logic [15:0] rData;
         logic        rRn;
         rIdx  = 4'($urandom_range(0, 15));
         rWe   = ($urandom_range(0, 3) == 0);
         rData = 16'($urandom);
         rRn   = ($urandom_range(0, 19) != 0);
         expY  = rRn ? modelTt[rIdx] : 1'b0;
         if (!rRn) begin
            modelTt = 16'h6996;
         end else if (rWe) begin
            modelTt = rData;
         end
         expYC = rRn ? modelTt[rIdx] : 1'b0;
         applyStimulus(rIdx, rWe, rData, rRn);
         checkOutput("rand_y_reg", {15'd0, yR}, {15'd0, expY});
         checkOutput("rand_tt", ttR, modelTt);
         checkOutput("rand_y_comb", {15'd0, yC}, {15'd0, expYC});
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
